// File: rtl/disp_scheduler.sv
// Round-robin scheduler that time-multiplexes NUM_SRC 16-bit debug words onto
// one 7-segment display input, with fixed dwell, blank gaps, hold and manual advance.
module disp_scheduler #(
  parameter int NUM_SRC      = 4,
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int BLANK_CYCLES = 5_000_000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [16*NUM_SRC-1:0]      src_data,
  input  logic [NUM_SRC-1:0]         src_req,
  input  logic                       hold,
  input  logic                       next,
  output logic [15:0]                disp_data,
  output logic [$clog2(NUM_SRC)-1:0] disp_sel,
  output logic                       disp_valid,
  output logic                       sel_change
);
  localparam int SW = $clog2(NUM_SRC);
  localparam int DW = $clog2(DWELL_CYCLES);
  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd1, BLANK = 2'd2} state_t;

  typedef struct packed {
    logic          found;
    logic [SW-1:0] idx;
  } rr_t;

  // Scan from+1 .. from (wrapping); iterating backwards lets the nearest hit win.
  function automatic rr_t rr(input logic [SW-1:0] from, input logic [NUM_SRC-1:0] req);
    rr_t res;
    int  pos;
    res.found = 1'b0;
    res.idx   = from;
    for (int k = NUM_SRC; k >= 1; k--) begin
      pos = int'(from) + k;
      if (pos >= NUM_SRC) pos = pos - NUM_SRC;
      if (req[SW'(pos)]) begin
        res.found = 1'b1;
        res.idx   = SW'(pos);
      end
    end
    return res;
  endfunction

  logic [15:0] src_word [NUM_SRC];

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_word
      assign src_word[gi] = src_data[16*gi +: 16];
    end
  endgenerate

  state_t        state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [SW-1:0] nxt_q, nxt_d;
  logic [DW-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [BW-1:0] blank_cnt_q, blank_cnt_d;
  logic [15:0]   disp_data_q, disp_data_d;
  logic          disp_valid_q, disp_valid_d;
  logic          sel_change_q, sel_change_d;

  rr_t  rr_sel;
  rr_t  rr_nxt;
  logic advance;

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    nxt_d        = nxt_q;
    dwell_cnt_d  = dwell_cnt_q;
    blank_cnt_d  = blank_cnt_q;
    sel_change_d = 1'b0;
    rr_sel       = rr(sel_q, src_req);
    rr_nxt       = rr(nxt_q, src_req);
    advance      = (dwell_cnt_q == DWELL_LAST) || next || !src_req[sel_q];

    case (state_q)
      IDLE: begin
        if (rr_sel.found) begin
          sel_d        = rr_sel.idx;
          dwell_cnt_d  = '0;
          sel_change_d = 1'b1;
          state_d      = SHOW;
        end
      end
      SHOW: begin
        if (advance) begin
          if (!rr_sel.found) begin
            state_d = IDLE;
          end else if (rr_sel.idx == sel_q) begin
            dwell_cnt_d = '0;
          end else begin
            nxt_d       = rr_sel.idx;
            blank_cnt_d = '0;
            state_d     = BLANK;
          end
        end else if (!hold) begin
          dwell_cnt_d = dwell_cnt_q + DW'(1);
        end
      end
      BLANK: begin
        if (blank_cnt_q == BLANK_LAST) begin
          // Target may have withdrawn during the gap; fall back to the next requester.
          if (src_req[nxt_q]) begin
            sel_d        = nxt_q;
            dwell_cnt_d  = '0;
            sel_change_d = 1'b1;
            state_d      = SHOW;
          end else if (rr_nxt.found) begin
            sel_d        = rr_nxt.idx;
            dwell_cnt_d  = '0;
            sel_change_d = 1'b1;
            state_d      = SHOW;
          end else begin
            state_d = IDLE;
          end
        end else begin
          blank_cnt_d = blank_cnt_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    disp_valid_d = (state_d == SHOW);
    disp_data_d  = (state_d == SHOW) ? src_word[sel_d] : 16'h0000;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      nxt_q        <= '0;
      dwell_cnt_q  <= '0;
      blank_cnt_q  <= '0;
      disp_data_q  <= 16'h0000;
      disp_valid_q <= 1'b0;
      sel_change_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      nxt_q        <= nxt_d;
      dwell_cnt_q  <= dwell_cnt_d;
      blank_cnt_q  <= blank_cnt_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
      sel_change_q <= sel_change_d;
    end
  end

  assign disp_data  = disp_data_q;
  assign disp_sel   = sel_q;
  assign disp_valid = disp_valid_q;
  assign sel_change = sel_change_q;

endmodule

// File: tb/tb_disp_scheduler.sv
// Bench for disp_scheduler: directed scenarios plus random traffic, all checked
// every cycle against a behavioural round-robin/dwell/gap model.
module tb_disp_scheduler;
  localparam int N = 4;
  localparam int D = 8;
  localparam int B = 2;
  localparam int M_IDLE  = 0;
  localparam int M_SHOW  = 1;
  localparam int M_BLANK = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] src_data;
  logic [3:0]  req;
  logic        hold;
  logic        nxt_in;
  logic [15:0] disp_data;
  logic [1:0]  disp_sel;
  logic        disp_valid;
  logic        sel_change;

  int n_vec = 0;
  int n_err = 0;

  // model state: what is on screen, how long it has been up, what comes next
  int          m_mode;
  int          m_sel;
  int          m_target;
  int          m_age;
  int          m_gap;
  logic        m_change;
  logic        m_valid;
  logic [15:0] m_data;

  disp_scheduler #(.NUM_SRC(N), .DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .src_data   (src_data),
    .src_req    (req),
    .hold       (hold),
    .next       (nxt_in),
    .disp_data  (disp_data),
    .disp_sel   (disp_sel),
    .disp_valid (disp_valid),
    .sel_change (sel_change)
  );

  always #5 clk = ~clk;

  function automatic int rr_m(int from, logic [3:0] r);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (from + k) % N;
      if (r[2'(j)]) return j;
    end
    return -1;
  endfunction

  task automatic model_step();
    int t;
    m_change = 1'b0;
    if (!rst_n) begin
      m_mode = M_IDLE; m_sel = 0; m_target = 0; m_age = 0; m_gap = 0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          t = rr_m(m_sel, req);
          if (t >= 0) begin
            m_sel = t; m_mode = M_SHOW; m_age = 0; m_change = 1'b1;
          end
        end
        M_SHOW: begin
          if (m_age == D - 1 || nxt_in || !req[2'(m_sel)]) begin
            t = rr_m(m_sel, req);
            if (t < 0) m_mode = M_IDLE;
            else if (t == m_sel) m_age = 0;
            else begin
              m_target = t; m_gap = B; m_mode = M_BLANK;
            end
          end else if (!hold) begin
            m_age++;
          end
        end
        default: begin
          m_gap--;
          if (m_gap == 0) begin
            t = req[2'(m_target)] ? m_target : rr_m(m_target, req);
            if (t < 0) m_mode = M_IDLE;
            else begin
              m_sel = t; m_mode = M_SHOW; m_age = 0; m_change = 1'b1;
            end
          end
        end
      endcase
    end
    m_valid = (m_mode == M_SHOW);
    m_data  = m_valid ? src_data[16*m_sel +: 16] : 16'h0000;
  endtask

  task automatic compare();
    n_vec++;
    if (disp_valid !== m_valid || disp_sel !== 2'(m_sel) ||
        disp_data !== m_data || sel_change !== m_change) begin
      n_err++;
      $display("FAIL model t=%0t: got valid=%b sel=%0d data=%h chg=%b, want valid=%b sel=%0d data=%h chg=%b",
               $time, disp_valid, disp_sel, disp_data, sel_change,
               m_valid, m_sel, m_data, m_change);
    end
  endtask

  task automatic lit(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  initial begin
    int cnt_a;
    int cnt_b;
    int g;
    rst_n    = 1'b0;
    req      = 4'hF;
    src_data = 64'h4444_3333_2222_1111;
    hold     = 1'b0;
    nxt_in   = 1'b0;
    m_mode = M_IDLE; m_sel = 0; m_target = 0; m_age = 0; m_gap = 0;
    m_change = 1'b0; m_valid = 1'b0; m_data = 16'h0000;

    // reset
    repeat (3) cycle();
    lit("reset_valid", 16'(disp_valid), 16'h0);
    lit("reset_data", disp_data, 16'h0);
    lit("reset_sel", 16'(disp_sel), 16'h0);
    lit("reset_chg", 16'(sel_change), 16'h0);
    rst_n = 1'b1;
    cycle();
    lit("release_sel", 16'(disp_sel), 16'h1);
    lit("release_chg", 16'(sel_change), 16'h1);
    lit("release_data", disp_data, 16'h2222);
    $display("scenario reset done");

    // rotation over 1011: 1 -> 3 -> 0 -> 1
    req = 4'b1011;
    repeat (7) cycle();
    cycle();
    lit("rot_blank1_valid", 16'(disp_valid), 16'h0);
    cycle();
    lit("rot_blank2_data", disp_data, 16'h0);
    cycle();
    lit("rot_sel3", 16'(disp_sel), 16'h3);
    lit("rot_data3", disp_data, 16'h4444);
    lit("rot_chg3", 16'(sel_change), 16'h1);
    repeat (9) cycle();
    cycle();
    lit("rot_sel0", 16'(disp_sel), 16'h0);
    lit("rot_data0", disp_data, 16'h1111);
    repeat (9) cycle();
    cycle();
    lit("rot_sel1", 16'(disp_sel), 16'h1);
    lit("rot_data1", disp_data, 16'h2222);
    $display("scenario rotation done");

    // sole requester
    req = 4'b0100;
    repeat (3) cycle();
    lit("sole_sel", 16'(disp_sel), 16'h2);
    lit("sole_chg", 16'(sel_change), 16'h1);
    cnt_a = 0; cnt_b = 0;
    repeat (40) begin
      cycle();
      if (disp_valid !== 1'b1 || disp_sel !== 2'd2) cnt_a++;
      if (sel_change !== 1'b0) cnt_b++;
    end
    lit("sole_gaps", 16'(cnt_a), 16'h0);
    lit("sole_extra_chg", 16'(cnt_b), 16'h0);
    $display("scenario sole requester done");

    // hold versus next
    hold = 1'b1;
    cycle();
    req = 4'b0101;
    cnt_a = 0;
    repeat (20) begin
      cycle();
      if (disp_valid !== 1'b1 || disp_sel !== 2'd2) cnt_a++;
    end
    lit("hold_no_advance", 16'(cnt_a), 16'h0);
    nxt_in = 1'b1;
    cycle();
    nxt_in = 1'b0;
    lit("next_over_hold_valid", 16'(disp_valid), 16'h0);
    lit("next_over_hold_data", disp_data, 16'h0);
    $display("scenario hold/next done");

    // request drop during blank
    hold = 1'b0;
    req  = 4'b1001;
    cycle();
    cycle();
    lit("drop_pre_sel", 16'(disp_sel), 16'h0);
    nxt_in = 1'b1;
    cycle();
    nxt_in = 1'b0;
    lit("drop_blank_valid", 16'(disp_valid), 16'h0);
    req = 4'b0001;
    cycle();
    cycle();
    lit("drop_fallback_sel", 16'(disp_sel), 16'h0);
    lit("drop_fallback_valid", 16'(disp_valid), 16'h1);
    lit("drop_fallback_chg", 16'(sel_change), 16'h1);
    req    = 4'b1001;
    nxt_in = 1'b1;
    cycle();
    nxt_in = 1'b0;
    req    = 4'b0000;
    cycle();
    cycle();
    lit("drop_idle_valid", 16'(disp_valid), 16'h0);
    lit("drop_idle_data", disp_data, 16'h0);
    cycle();
    lit("drop_idle_stay", 16'(disp_valid), 16'h0);
    $display("scenario request drop done");

    // live data and next coinciding with dwell expiry
    req = 4'b0001;
    cycle();
    lit("live_first_data", disp_data, 16'h1111);
    src_data[15:0] = 16'hABCD;
    cycle();
    lit("live_follow", disp_data, 16'hABCD);
    req = 4'b0011;
    g = 0;
    while (m_age != D - 1 && g < 20) begin
      cycle();
      g++;
    end
    lit("expiry_reached", 16'(g < 20), 16'h1);
    nxt_in = 1'b1;
    cycle();
    nxt_in = 1'b0;
    lit("simul_blank1", 16'(disp_valid), 16'h0);
    cycle();
    lit("simul_blank2", 16'(disp_valid), 16'h0);
    cycle();
    lit("simul_sel", 16'(disp_sel), 16'h1);
    lit("simul_chg", 16'(sel_change), 16'h1);
    cycle();
    lit("simul_single", 16'(sel_change), 16'h0);
    $display("scenario live data/simultaneous done");

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n  = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 9) == 0) req = 4'($urandom);
      if ($urandom_range(0, 3) == 0) src_data = {$urandom, $urandom};
      if ($urandom_range(0, 15) == 0) hold = ~hold;
      nxt_in = ($urandom_range(0, 19) == 0);
      cycle();
    end
    $display("scenario random done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/disp_scheduler.md
# disp_scheduler

Time-multiplexes up to NUM_SRC 16-bit debug values (register contents, PC, memory word, …) onto the single 16-bit input of the 4-digit 7-segment display driver. Round-robins among the sources currently requesting, dwelling a fixed number of cycles on each. It inserts a blank gap between sources and supports a hold input and a manual-advance input for board buttons. It sits between the CPU debug taps and the display driver's `regData` input.

## Interface
- `NUM_SRC`, 4, number of sources; range 2..8.
- `DWELL_CYCLES`, 50_000_000, cycles each source is shown; minimum 2.
- `BLANK_CYCLES`, 5_000_000, cycles of blank gap between different sources; minimum 1.
- `clk` in 1: system clock. One clock domain; everything is on `posedge clk`.
- `reset` in 1: synchronous, active-low reset.
- `src_data` in 16*NUM_SRC: source i occupies bits [16i+15:16i].
- `src_req` in NUM_SRC: bit i set means source i wants display time. Level-sensitive.
- `hold` in 1: freezes the dwell counter while in SHOW.
- `next` in 1: single-cycle pulse that forces an advance. Debounced upstream.
- `disp_data` out 16: value to the display driver.
- `disp_sel` out clog2(NUM_SRC): index currently shown.
- `disp_valid` out 1: high while a source is being shown.
- `sel_change` out 1: one-cycle pulse when a new source starts showing.

## Operation
- The states are IDLE, SHOW and BLANK. Internal registers are `sel`, `nxt`, `dwell_cnt` and `blank_cnt`.
- **Reset** (`reset`=0 at an edge): state IDLE, `sel`=0, `nxt`=0, both counters 0, `disp_data`=16'h0000, `disp_valid`=0, `sel_change`=0. Reset overrides every other input.
- **Round-robin search** `rr(from)`: the first index j with `src_req[j]`=1, scanning from+1, from+2, … mod NUM_SRC and ending at `from` itself. It returns "none" if `src_req`=0.
- **IDLE**:
  - If `src_req`≠0, `sel` ← rr(`sel`), go to SHOW, `dwell_cnt` ← 0, `sel_change` pulses.
  - Otherwise stay in IDLE.
- **SHOW**: `dwell_cnt` increments each cycle unless `hold`=1.
  - An advance event is any of: `dwell_cnt`==DWELL_CYCLES-1, `next`=1, or `src_req[sel]`=0. `next` overrides `hold`. Simultaneous triggers give exactly one advance.
  - On an advance, t = rr(`sel`):
    - t = none: go to IDLE.
    - t = `sel` (sole requester): stay in SHOW, `dwell_cnt` ← 0, no `sel_change`, no blank.
    - otherwise: `nxt` ← t, `blank_cnt` ← 0, go to BLANK.
- **BLANK**: `blank_cnt` increments each cycle. `next` and `hold` are ignored.
  - At `blank_cnt`==BLANK_CYCLES-1, the target is re-validated:
    - If `src_req[nxt]`=1, `sel` ← `nxt`.
    - Otherwise `sel` ← rr(`nxt`). If that is none, go to IDLE.
  - On success, go to SHOW with `dwell_cnt` ← 0 and `sel_change` pulsed.
- **Outputs**:
  - `disp_valid`=1 exactly in the cycles where the state is SHOW.
  - `disp_data` is 16'h0000 in IDLE and BLANK.
  - In SHOW, `disp_data` is src_data[`sel`] registered, i.e. the value sampled at the previous edge.
  - `disp_sel` = `sel` at all times.
- Counter widths are clog2 of the respective parameter. Counters never wrap, because they are reset before reaching their terminal value.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Request to display: `src_req` rises at edge k (while in IDLE). SHOW, `disp_valid`=1, `sel_change`=1 and valid `disp_data` all appear after edge k+1.
- With no hold and no `next`, a source is shown for exactly DWELL_CYCLES cycles.
- The BLANK gap between two different sources is exactly BLANK_CYCLES cycles.
- A `next` pulse in SHOW at edge k gives BLANK from edge k+1.
- `sel_change` is high for exactly one cycle, coincident with the first SHOW cycle of the new `sel`.
- A source whose `src_req` drops mid-SHOW gives BLANK (or IDLE) at the next edge.

## Test plan
Parameters for all scenarios: NUM_SRC=4, DWELL_CYCLES=8, BLANK_CYCLES=2.
1. **Reset**: hold `reset`=0 for 3 cycles while `src_req`=4'hF. Required: all outputs 0 and state IDLE. Release reset: SHOW sel=1 (rr(0)) one cycle later, `sel_change`=1.
2. **Rotation**: `src_req`=4'b1011 with data 16'h1111/2222/3333/4444. Required: the shown sequence is sel 1, 3, 0, 1, …, each shown 8 cycles with `disp_data` 16'h2222, 16'h4444, 16'h1111. Between each pair there are 2 cycles of `disp_valid`=0 and `disp_data`=0.
3. **Sole requester**: `src_req`=4'b0100 for 40 cycles. Required: `disp_valid` stays continuously 1 with sel=2, no BLANK, and `sel_change` only once.
4. **Hold versus next**: `hold`=1 in SHOW for 20 cycles. Required: no advance. Then pulse `next` with `hold` still 1. Required: BLANK on the next edge.
5. **Request drop**: in BLANK targeting `nxt`=3, drop `src_req[3]` leaving only bit 0. Required: SHOW sel=0 after the blank. If `src_req` is dropped to 0 instead, required: IDLE with `disp_valid`=0.
6. **Live data and simultaneous events**:
   - Change `src_data` mid-SHOW. Required: `disp_data` follows one cycle later.
   - Assert `next` on the same edge as dwell expiry. Required: exactly one BLANK and one advance.
